// File: rtl/iir_frame_ctrl.sv
// iir_frame_ctrl - frame sequencer for the shift-add IIR filter core.
//
// Accepts a start command (length + base addresses), issues sample reads,
// advances/clears the filter core, and issues result writes once the core's
// latency has elapsed. Raises Finish once per frame.
//
// Optional feature macro: IIR_CTRL_FLUSH_EN
//   defined   : CLEAR state present, core_clr pulses once per frame
//   undefined : no CLEAR state, core_clr tied low (history streams on)
//
// Parameters: AW  address/length width
//             LAT cycles from a core_en cycle to the matching valid result
// Ports:
//   clk, rst (async, active-high)
//   start, frame_len, base_raddr, base_waddr : command
//   gnt, data_done                           : input-memory side
//   load, RAddr                              : read request
//   core_en, core_clr                        : filter core control
//   WEN, WAddr                               : result write
//   Finish, busy, wr_cnt                     : status
module iir_frame_ctrl #(
  parameter int AW  = 20,
  parameter int LAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] frame_len,
  input  logic [AW-1:0] base_raddr,
  input  logic [AW-1:0] base_waddr,
  input  logic          gnt,
  input  logic          data_done,
  output logic          load,
  output logic [AW-1:0] RAddr,
  output logic          core_en,
  output logic          core_clr,
  output logic          WEN,
  output logic [AW-1:0] WAddr,
  output logic          Finish,
  output logic          busy,
  output logic [AW-1:0] wr_cnt
);

  localparam logic [AW-1:0] ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          start_ok_s;
  logic          issue_s;
  logic          last_rd_s;
  logic          pending_s;
  logic [AW-1:0] raddr_r;
  logic [AW-1:0] waddr_r;
  logic [AW-1:0] rd_cnt_r;
  logic [AW-1:0] len_r;
  logic [AW-1:0] wr_cnt_r;
  // Bit 0 mirrors core_en; bit LAT is the write strobe.
  logic [LAT:0]  vpipe_r;

  assign start_ok_s = (state_r == S_IDLE) && start;
  assign issue_s    = load && gnt;
  assign last_rd_s  = ((rd_cnt_r + ONE) == len_r);

  // Samples still in flight that will strobe WEN in a later cycle.
  always_comb begin
    pending_s = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pending_s = pending_s | vpipe_r[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!start) begin
          state_nxt_s = S_IDLE;
        end else if (frame_len == ZERO) begin
          state_nxt_s = S_DONE;
        end else begin
`ifdef IIR_CTRL_FLUSH_EN
          state_nxt_s = S_CLEAR;
`else
          state_nxt_s = S_RUN;
`endif
        end
      end
`ifdef IIR_CTRL_FLUSH_EN
      S_CLEAR: state_nxt_s = S_RUN;
`endif
      S_RUN: begin
        // data_done wins over a read that would have reached the final count.
        if (data_done) begin
          state_nxt_s = S_DRAIN;
        end else if (issue_s && last_rd_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (pending_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State-decoded outputs; load follows data_done combinationally in RUN.
  always_comb begin
    load     = 1'b0;
    core_clr = 1'b0;
    Finish   = 1'b0;
    busy     = 1'b1;
    case (state_r)
      S_IDLE:  busy = 1'b0;
`ifdef IIR_CTRL_FLUSH_EN
      S_CLEAR: core_clr = 1'b1;
`endif
      S_RUN:   load = !data_done;
      S_DRAIN: load = 1'b0;
      S_DONE:  Finish = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Frame counters, address generators and the valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr_r  <= ZERO;
      waddr_r  <= ZERO;
      rd_cnt_r <= ZERO;
      len_r    <= ZERO;
      wr_cnt_r <= ZERO;
      vpipe_r  <= '0;
    end else begin
      vpipe_r[0] <= issue_s;
      for (int i = 1; i <= LAT; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
      end
      if (start_ok_s) begin
        raddr_r  <= base_raddr;
        waddr_r  <= base_waddr;
        rd_cnt_r <= ZERO;
        len_r    <= frame_len;
        wr_cnt_r <= ZERO;
      end else begin
        if (issue_s) begin
          raddr_r  <= raddr_r + ONE;
          rd_cnt_r <= rd_cnt_r + ONE;
        end
        if (vpipe_r[LAT]) begin
          waddr_r  <= waddr_r + ONE;
          wr_cnt_r <= wr_cnt_r + ONE;
        end
      end
    end
  end

  assign RAddr   = raddr_r;
  assign WAddr   = waddr_r;
  assign wr_cnt  = wr_cnt_r;
  assign core_en = vpipe_r[0];
  assign WEN     = vpipe_r[LAT];

endmodule
